// File: rtl/async_fifo_wptr_full.sv
// async_fifo_wptr_full: write-domain pointer, read-pointer synchroniser and
// registered full / almost-full / level / overflow status for an async FIFO.
module async_fifo_wptr_full #(
   parameter int ADDR_WIDTH = 6,
   parameter int DEPTH      = 2**ADDR_WIDTH,
   parameter int AF_MARGIN  = 4
) (
   input  logic                  wclk,
   input  logic                  wreset_n,
   input  logic                  winc,
   input  logic [ADDR_WIDTH:0]   rptr_gray,
   output logic                  wen,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [ADDR_WIDTH:0]   wptr_gray,
   output logic                  wfull,
   output logic                  wafull,
   output logic [ADDR_WIDTH:0]   wlevel,
   output logic                  woverflow
);
   localparam int A  = ADDR_WIDTH;
   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [A:0] AF_TH = PW'(DEPTH - AF_MARGIN);
   logic [A:0] wbin_q, wbin_d, wgray_q, wgray_d, rq1_q, rq2_q, rbin_s, wlevel_q, wlevel_d;
   logic       wfull_q, wfull_d, wafull_q, wafull_d, wovf_q, wovf_d;
   assign wen       = winc & ~wfull_q;
   assign waddr     = wbin_q[A-1:0];
   assign wptr_gray = wgray_q;
   assign wfull     = wfull_q;
   assign wafull    = wafull_q;
   assign wlevel    = wlevel_q;
   assign woverflow = wovf_q;
   // Gray-to-binary: each bit is the XOR of all synchronised bits at or above it
   for (genvar i = 0; i <= A; i++) begin : g_g2b
      assign rbin_s[i] = ^rq2_q[A:i];
   end
   always_comb begin
      wbin_d   = wbin_q + PW'(wen);
      wgray_d  = wbin_d ^ (wbin_d >> 1);
      wlevel_d = wbin_d - rbin_s;
      wfull_d  = wgray_d == {~rq2_q[A:A-1], rq2_q[A-2:0]};
      wafull_d = wlevel_d >= AF_TH;
      wovf_d   = wovf_q | (winc & wfull_q);
   end
   always_ff @(posedge wclk) begin
      if (!wreset_n) begin
         wbin_q   <= '0;
         wgray_q  <= '0;
         rq1_q    <= '0;
         rq2_q    <= '0;
         wlevel_q <= '0;
         wfull_q  <= 1'b0;
         wafull_q <= 1'b0;
         wovf_q   <= 1'b0;
      end else begin
         wbin_q   <= wbin_d;
         wgray_q  <= wgray_d;
         rq1_q    <= rptr_gray;
         rq2_q    <= rq1_q;
         wlevel_q <= wlevel_d;
         wfull_q  <= wfull_d;
         wafull_q <= wafull_d;
         wovf_q   <= wovf_d;
      end
   end
endmodule

// File: tb/tb_async_fifo_wptr_full.sv
// tb_async_fifo_wptr_full: table vectors, directed corner sequences and a
// randomized stream checked against a count-based occupancy model.
module tb_async_fifo_wptr_full;
   localparam int AW = 6;
   localparam int DEPTH = 64;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          winc = 1'b0;
   logic [AW:0]   rptr_g;
   logic          wen;
   logic [AW-1:0] waddr;
   logic [AW:0]   wptr_gray;
   logic          wfull, wafull, woverflow;
   logic [AW:0]   wlevel;
   int            rd_cnt = 0;
   logic [AW:0]   rd7;
   int            n_pass = 0, n_tot = 0;
   // model: write count and read counts seen at the last two edges
   logic [AW:0]   m_wr = '0, m_lvl = '0, s1 = '0, s2 = '0;
   logic          m_full = 1'b0, m_af = 1'b0, m_ovf = 1'b0;
   int            wr_total = 0;

   typedef struct {
      logic rst_n; logic winc; int rd; int lvl; logic full; int waddr;
   } vec_t;
   vec_t tbl[11];

   assign rd7    = 7'(rd_cnt);
   assign rptr_g = rd7 ^ (rd7 >> 1);

   always #5 clk = ~clk;

   async_fifo_wptr_full #(.ADDR_WIDTH(AW), .AF_MARGIN(4)) dut (
      .wclk(clk), .wreset_n(rst_n), .winc(winc), .rptr_gray(rptr_g),
      .wen(wen), .waddr(waddr), .wptr_gray(wptr_gray), .wfull(wfull),
      .wafull(wafull), .wlevel(wlevel), .woverflow(woverflow)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic tick();
      logic       acc;
      logic [AW:0] prev_g;
      prev_g = wptr_gray;
      @(posedge clk);
      if (!rst_n) begin
         m_wr = '0; m_lvl = '0; s1 = '0; s2 = '0;
         m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0; wr_total = 0;
      end else begin
         acc      = winc & ~m_full;
         m_ovf    = m_ovf | (winc & m_full);
         m_wr     = m_wr + 7'(acc);
         wr_total = wr_total + int'(acc);
         m_lvl    = m_wr - s2;
         m_full   = m_lvl == 7'(DEPTH);
         m_af     = m_lvl >= 7'(DEPTH - 4);
         s2       = s1;
         s1       = 7'(rd_cnt);
      end
      #1;
      chk("m_wfull", int'(wfull), int'(m_full));
      chk("m_wafull", int'(wafull), int'(m_af));
      chk("m_wlevel", int'(wlevel), int'(m_lvl));
      chk("m_woverflow", int'(woverflow), int'(m_ovf));
      chk("m_waddr", int'(waddr), int'(m_wr[AW-1:0]));
      chk("m_wptr_gray", int'(wptr_gray), int'(m_wr ^ (m_wr >> 1)));
      chk("m_wen", int'(wen), int'(winc & ~m_full));
      chk("inv_full_level", int'(wfull), int'(wlevel == 7'(DEPTH)));
      if (rst_n) chk("gray_one_bit", int'($countones(wptr_gray ^ prev_g) <= 1), 1);
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0; winc = 1'b0; rd_cnt = 0;
      for (int i = 0; i < n; i++) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int cyc;
      tbl[0]  = '{1'b0, 1'b1, 0, 0, 1'b0, 0};
      tbl[1]  = '{1'b0, 1'b1, 0, 0, 1'b0, 0};
      tbl[2]  = '{1'b0, 1'b1, 0, 0, 1'b0, 0};
      tbl[3]  = '{1'b1, 1'b1, 0, 1, 1'b0, 1};
      tbl[4]  = '{1'b1, 1'b1, 0, 2, 1'b0, 2};
      tbl[5]  = '{1'b1, 1'b0, 1, 2, 1'b0, 2};
      tbl[6]  = '{1'b1, 1'b0, 1, 2, 1'b0, 2};
      tbl[7]  = '{1'b1, 1'b0, 1, 1, 1'b0, 2};
      tbl[8]  = '{1'b1, 1'b1, 2, 2, 1'b0, 3};
      tbl[9]  = '{1'b1, 1'b0, 2, 2, 1'b0, 3};
      tbl[10] = '{1'b1, 1'b0, 2, 1, 1'b0, 3};
      for (int i = 0; i < 11; i++) begin
         rst_n = tbl[i].rst_n; winc = tbl[i].winc; rd_cnt = tbl[i].rd;
         tick();
         chk($sformatf("vec%0d_wlevel", i), int'(wlevel), tbl[i].lvl);
         chk($sformatf("vec%0d_wfull", i), int'(wfull), int'(tbl[i].full));
         chk($sformatf("vec%0d_waddr", i), int'(waddr), tbl[i].waddr);
         if (i < 3) chk("reset_wen", int'(wen), 1);
      end
      // fill to full with the read pointer parked at 0
      do_reset(2);
      for (int i = 0; i < DEPTH; i++) begin
         chk("fill_waddr", int'(waddr), i);
         winc = 1'b1;
         tick();
         chk("fill_wafull", int'(wafull), int'(i + 1 >= DEPTH - 4));
      end
      chk("full_wfull", int'(wfull), 1);
      chk("full_wlevel", int'(wlevel), DEPTH);
      chk("full_gray", int'(wptr_gray), 7'b1100000);
      // overflow attempts while full
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("ovf_wen", int'(wen), 0);
         chk("ovf_waddr", int'(waddr), 0);
         chk("ovf_flag", int'(woverflow), 1);
      end
      winc = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("ovf_sticky", int'(woverflow), 1);
      // one read released: full clears on the third edge
      rd_cnt = 1;
      tick(); chk("rel_e0_full", int'(wfull), 1);
      tick(); chk("rel_e1_full", int'(wfull), 1);
      tick(); chk("rel_e2_full", int'(wfull), 0);
      chk("rel_wlevel", int'(wlevel), DEPTH - 1);
      chk("rel_waddr", int'(waddr), 0);
      winc = 1'b1;
      tick();
      winc = 1'b0;
      chk("refill_wfull", int'(wfull), 1);
      chk("refill_wlevel", int'(wlevel), DEPTH);
      // randomized stream with a draining read domain, wrapping the pointers
      do_reset(2);
      cyc = 0;
      while (wr_total < 300 && cyc < 4000) begin
         winc = !m_full && ($urandom_range(0, 7) != 0);
         if (rd_cnt < wr_total && $urandom_range(0, 2) != 0) rd_cnt++;
         tick();
         cyc++;
      end
      winc = 1'b0;
      chk("wrap_writes_done", int'(wr_total >= 300), 1);
      chk("wrap_no_overflow", int'(woverflow), 0);
      // reset in the middle of operation
      do_reset(2);
      winc = 1'b1;
      for (int i = 0; i < 37; i++) tick();
      chk("mid_wlevel", int'(wlevel), 37);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; winc = 1'b0;
      chk("midrst_wlevel", int'(wlevel), 0);
      chk("midrst_waddr", int'(waddr), 0);
      tick();
      chk("post_wlevel", int'(wlevel), 0);
      chk("post_wfull", int'(wfull), 0);
      chk("post_waddr", int'(waddr), 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
